// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/memory/IO/writeback control FSM
module core_sequencer #(
    parameter int         IMEM_LATENCY  = 2,
    parameter logic [2:0] PC_SRC_FINISH = 3'b100,
    parameter int         CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic             reg_write_enable,
    input  logic             ram_read,
    input  logic             ram_write_enable,
    input  logic             stdin_read_enable,
    input  logic             stdout_write_enable,
    input  logic [2:0]       next_pc_src,
    input  logic             alu_multicycle,
    input  logic             alu_done,
    input  logic             ram_ready,
    input  logic             stdin_valid,
    input  logic             stdout_ready,
    output logic             ir_write,
    output logic             alu_start,
    output logic             ram_req,
    output logic             ram_we,
    output logic             stdin_pop,
    output logic             stdout_push,
    output logic             rf_we,
    output logic             pc_we,
    output logic             busy,
    output logic             finished,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        IO     = 3'd5,
        WB     = 3'd6,
        HALT   = 3'd7
    } state_e;

    localparam int CW = (IMEM_LATENCY > 1) ? $clog2(IMEM_LATENCY) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             io_go;

    // State, fetch counter, first-EXEC-cycle flag and retired count registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and Moore/handshake strobes; the first EXEC cycle masks alu_done
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = 1'b0;
        retired_d   = retired_q;
        ir_write    = 1'b0;
        alu_start   = 1'b0;
        ram_req     = 1'b0;
        ram_we      = 1'b0;
        stdin_pop   = 1'b0;
        stdout_push = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
        finished    = 1'b0;
        io_go       = stdin_read_enable ? stdin_valid : stdout_ready;
        case (state_q)
            IDLE: state_d = run ? FETCH : IDLE;
            FETCH: begin
                ir_write = (cnt_q == CW'(IMEM_LATENCY - 1));
                cnt_d    = ir_write ? '0 : cnt_q + CW'(1);
                state_d  = ir_write ? DECODE : FETCH;
            end
            DECODE: begin
                first_d = 1'b1;
                state_d = (next_pc_src == PC_SRC_FINISH) ? HALT : EXEC;
            end
            EXEC: begin
                alu_start = alu_multicycle & first_q;
                if (!alu_multicycle || (!first_q && alu_done))
                    state_d = (ram_read | ram_write_enable) ? MEM :
                              (stdin_read_enable | stdout_write_enable) ? IO : WB;
            end
            MEM: begin
                ram_req = 1'b1;
                ram_we  = ram_write_enable;
                state_d = ram_ready ? WB : MEM;
            end
            IO: begin
                stdin_pop   = stdin_read_enable & stdin_valid;
                stdout_push = !stdin_read_enable & stdout_ready;
                state_d     = io_go ? WB : IO;
            end
            WB: begin
                rf_we     = reg_write_enable;
                pc_we     = 1'b1;
                retired_d = retired_q + CNT_W'(1);
                state_d   = FETCH;
            end
            HALT: finished = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE) && (state_q != HALT);
    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed cycle-by-cycle scoreboard check of core_sequencer
module tb_core_sequencer;

    localparam int LAT = 2;
    localparam int CW  = 3;

    // strobe bit positions in {ir,alu_start,ram_req,ram_we,pop,push,rf_we,pc_we,busy,finished}
    localparam logic [9:0] IR   = 10'b1000000000;
    localparam logic [9:0] AS   = 10'b0100000000;
    localparam logic [9:0] RQ   = 10'b0010000000;
    localparam logic [9:0] WE   = 10'b0001000000;
    localparam logic [9:0] POP  = 10'b0000100000;
    localparam logic [9:0] PUSH = 10'b0000010000;
    localparam logic [9:0] RF   = 10'b0000001000;
    localparam logic [9:0] PC   = 10'b0000000100;
    localparam logic [9:0] BSY  = 10'b0000000010;
    localparam logic [9:0] FIN  = 10'b0000000001;
    localparam logic [9:0] NONE = 10'b0000000000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic run = 1'b0;
    logic reg_write_enable = 1'b0, ram_read = 1'b0, ram_write_enable = 1'b0;
    logic stdin_read_enable = 1'b0, stdout_write_enable = 1'b0;
    logic [2:0] next_pc_src = 3'b000;
    logic alu_multicycle = 1'b0, alu_done = 1'b0, ram_ready = 1'b0;
    logic stdin_valid = 1'b0, stdout_ready = 1'b0;
    logic ir_write, alu_start, ram_req, ram_we, stdin_pop, stdout_push;
    logic rf_we, pc_we, busy, finished;
    logic [CW-1:0] retired;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;
    logic [CW-1:0] exp_ret = '0;
    logic [12:0] exp_q[$];
    string tag_q[$];

    core_sequencer #(.IMEM_LATENCY(LAT), .PC_SRC_FINISH(3'b100), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .run(run),
        .reg_write_enable(reg_write_enable), .ram_read(ram_read),
        .ram_write_enable(ram_write_enable), .stdin_read_enable(stdin_read_enable),
        .stdout_write_enable(stdout_write_enable), .next_pc_src(next_pc_src),
        .alu_multicycle(alu_multicycle), .alu_done(alu_done), .ram_ready(ram_ready),
        .stdin_valid(stdin_valid), .stdout_ready(stdout_ready),
        .ir_write(ir_write), .alu_start(alu_start), .ram_req(ram_req), .ram_we(ram_we),
        .stdin_pop(stdin_pop), .stdout_push(stdout_push), .rf_we(rf_we), .pc_we(pc_we),
        .busy(busy), .finished(finished), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // push expectation for the current cycle, compare at negedge, advance to #1 after next posedge
    task automatic cyc(input string tag, input logic [9:0] s, input logic [2:0] st);
        logic [12:0] e, obs;
        string t;
        exp_q.push_back({s, st});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        obs = {ir_write, alu_start, ram_req, ram_we, stdin_pop, stdout_push,
               rf_we, pc_we, busy, finished, state};
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed outputs %b required %b", t, obs, e);
        end
        vectors++;
        assert (retired === exp_ret) else begin
            miscompares++;
            $error("FAIL %s_retired: observed %0d required %0d", t, retired, exp_ret);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic rw, input logic rr, input logic rwe, input logic si,
                             input logic so, input logic [2:0] pcs, input logic mc);
        reg_write_enable = rw; ram_read = rr; ram_write_enable = rwe;
        stdin_read_enable = si; stdout_write_enable = so; next_pc_src = pcs; alu_multicycle = mc;
    endtask

    task automatic fetch();
        for (int i = 0; i < LAT - 1; i++) cyc("fetch", BSY, 3'd1);
        cyc("fetch_ir", IR | BSY, 3'd1);
        cyc("decode", BSY, 3'd2);
    endtask

    task automatic wb(input logic rf);
        cyc("wb", (rf ? RF : NONE) | PC | BSY, 3'd6);
        exp_ret = exp_ret + 1'b1;
    endtask

    initial begin
        // reset and IDLE with run low
        #12;
        cyc("reset", NONE, 3'd0);
        rstn = 1'b1;
        cyc("idle", NONE, 3'd0);
        run = 1'b1;
        cyc("idle_run", NONE, 3'd0);
        run = 1'b0;

        // ADD: ir_write at cycle 2, WB at cycle 5
        set_instr(1, 0, 0, 0, 0, 3'b000, 0);
        fetch();
        cyc("add_exec", BSY, 3'd3);
        wb(1);

        // load with ram_ready low three MEM cycles
        set_instr(1, 1, 0, 0, 0, 3'b000, 0);
        fetch();
        cyc("ld_exec", BSY, 3'd3);
        for (int i = 0; i < 3; i++) cyc("ld_mem_wait", RQ | BSY, 3'd4);
        ram_ready = 1'b1;
        cyc("ld_mem_rdy", RQ | BSY, 3'd4);
        ram_ready = 1'b0;
        wb(1);

        // DIV: alu_done high in the start cycle must be ignored
        set_instr(1, 0, 0, 0, 0, 3'b000, 1);
        fetch();
        alu_done = 1'b1;
        cyc("div_start", AS | BSY, 3'd3);
        alu_done = 1'b0;
        for (int i = 0; i < 5; i++) cyc("div_wait", BSY, 3'd3);
        alu_done = 1'b1;
        cyc("div_done", BSY, 3'd3);
        alu_done = 1'b0;
        wb(1);

        // stdout with ready low four cycles; stdin_valid high must not pop
        set_instr(0, 0, 0, 0, 1, 3'b000, 0);
        fetch();
        stdin_valid = 1'b1;
        cyc("out_exec", BSY, 3'd3);
        for (int i = 0; i < 4; i++) cyc("out_wait", BSY, 3'd5);
        stdout_ready = 1'b1;
        cyc("out_push", PUSH | BSY, 3'd5);
        stdout_ready = 1'b0;
        stdin_valid = 1'b0;
        wb(0);

        // stdin with valid late; stdout_ready high must not push
        set_instr(1, 0, 0, 1, 0, 3'b000, 0);
        fetch();
        stdout_ready = 1'b1;
        cyc("in_exec", BSY, 3'd3);
        for (int i = 0; i < 2; i++) cyc("in_wait", BSY, 3'd5);
        stdin_valid = 1'b1;
        cyc("in_pop", POP | BSY, 3'd5);
        stdin_valid = 1'b0;
        stdout_ready = 1'b0;
        wb(1);

        // three ADDs take the 3-bit counter from 5 through 7 to 0
        set_instr(1, 0, 0, 0, 0, 3'b000, 0);
        for (int k = 0; k < 3; k++) begin
            fetch();
            cyc("add_exec", BSY, 3'd3);
            wb(1);
        end
        vectors++;
        assert (retired === 3'd0) else begin
            miscompares++;
            $error("FAIL wrap: observed %0d required 0", retired);
        end

        // store stalled in MEM, then asynchronous reset mid-stall
        set_instr(0, 0, 1, 0, 0, 3'b000, 0);
        fetch();
        cyc("st_exec", BSY, 3'd3);
        cyc("st_mem_wait", RQ | WE | BSY, 3'd4);
        rstn = 1'b0;
        exp_ret = '0;
        cyc("async_reset", NONE, 3'd0);
        rstn = 1'b1;
        set_instr(1, 0, 0, 0, 0, 3'b000, 0);
        run = 1'b1;
        cyc("restart_idle", NONE, 3'd0);
        run = 1'b0;
        fetch();
        cyc("restart_exec", BSY, 3'd3);
        wb(1);

        // FINISH: HALT after DECODE, run pulses ignored, pc_we stays low
        set_instr(1, 0, 0, 0, 0, 3'b100, 0);
        fetch();
        for (int i = 0; i < 3; i++) begin
            run = i[0];
            cyc("halt", FIN, 3'd7);
        end
        run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
